pc_sequencer: RTL and testbench

Fetch-stage controller owning the PC and pre-PC registers that feed the next-PC logic. Each cycle it samples the computed next PC, drives a req/ack instruction-memory port and presents the fetched instruction with its address to decode. It absorbs memory wait states and decode stalls, holding a one-entry skid buffer, and implements MIPS single-delay-slot sequencing.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/fetch_skid.sv | 33 +++
 rtl/pc_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch-stage sequencer: sequencer states,
// reset and exception vectors, instruction width and PC alignment helper.
package mips_pkg;

   localparam int unsigned INST_W   = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC   = 32'h0000_4180;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } seq_state_t;

   // Every PC loaded into the sequencer is word aligned.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry instruction skid buffer: holds a word returned by memory while
// decode is stalled. clear has priority over load, load over unload.
module fetch_skid
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              unload,
   input  logic              clear,
   input  logic [INST_W-1:0] din,
   output logic [INST_W-1:0] dout,
   output logic              full
);

   // Occupancy flag and captured word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         dout <= '0;
      end else begin
         if (clear) begin
            full <= 1'b0;
         end else if (load) begin
            full <= 1'b1;
            dout <= din;
         end else if (unload) begin
            full <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns PC / pre-PC, drives the req/ack instruction
// memory port, absorbs wait states and decode stalls through a one-entry
// skid buffer, and sequences MIPS single delay slots.
// Optional exception redirect enabled by defining PC_SEQ_EXC_EN.
module pc_sequencer
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       npc_i,
   input  logic              stall_i,
   output logic              imem_req_o,
   output logic [31:0]       imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [INST_W-1:0] imem_rdata_i,
   output logic [31:0]       pc_o,
   output logic [31:0]       pre_pc_o,
   output logic [INST_W-1:0] inst_o,
   output logic              inst_valid_o
`ifdef PC_SEQ_EXC_EN
   ,
   input  logic              exc_i,
   output logic [31:0]       epc_o
`endif
);

   seq_state_t        state;
   seq_state_t        state_next;
   logic              load_mem;
   logic              load_skid;
   logic              bubble;
   logic              skid_load;
   logic              skid_clear;
   logic              skid_full;
   logic [INST_W-1:0] skid_word;
   logic [31:0]       target;
`ifdef PC_SEQ_EXC_EN
   logic              exc_take;
   logic [31:0]       drain_addr;
`endif

   // Next-PC controls are only meaningful for a real instruction in decode.
   assign target = align_pc(inst_valid_o ? npc_i : pc_o + 32'd4);

   fetch_skid u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (skid_load),
      .unload (load_skid),
      .clear  (skid_clear),
      .din    (imem_rdata_i),
      .dout   (skid_word),
      .full   (skid_full)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next state and datapath control decisions.
   always_comb begin
      state_next = state;
      load_mem   = 1'b0;
      load_skid  = 1'b0;
      bubble     = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
`ifdef PC_SEQ_EXC_EN
      exc_take   = 1'b0;
`endif
      case (state)
         IDLE: state_next = FETCH;
         FETCH: begin
            if (imem_ack_i) begin
               if (stall_i) begin
                  skid_load  = 1'b1;
                  state_next = WAIT;
               end else begin
                  load_mem = 1'b1;
               end
            end else if (!stall_i) begin
               bubble = 1'b1;
            end
         end
         WAIT: begin
            if (!stall_i && skid_full) begin
               load_skid  = 1'b1;
               state_next = FETCH;
            end
         end
`ifdef PC_SEQ_EXC_EN
         DRAIN: if (imem_ack_i) state_next = FETCH;
`endif
         default: state_next = IDLE;
      endcase
`ifdef PC_SEQ_EXC_EN
      // Exception overrides every decision above, stall included; an
      // unanswered request must still be drained before refetching.
      if (exc_i) begin
         load_mem   = 1'b0;
         load_skid  = 1'b0;
         bubble     = 1'b0;
         skid_load  = 1'b0;
         skid_clear = 1'b1;
         exc_take   = 1'b1;
         state_next = ((state == FETCH || state == DRAIN) && !imem_ack_i) ? DRAIN : FETCH;
      end
`endif
   end

   // Memory port outputs.
   always_comb begin
      imem_req_o  = (state == FETCH);
      imem_addr_o = pc_o;
`ifdef PC_SEQ_EXC_EN
      if (state == DRAIN) begin
         imem_req_o  = 1'b1;
         imem_addr_o = drain_addr;
      end
`endif
   end

   // PC, pre-PC and decode registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_o         <= RESET_PC;
         pre_pc_o     <= RESET_PC;
         inst_o       <= '0;
         inst_valid_o <= 1'b0;
      end else begin
`ifdef PC_SEQ_EXC_EN
         if (exc_take) begin
            pc_o         <= EXC_PC;
            inst_valid_o <= 1'b0;
         end else
`endif
         if (load_mem || load_skid) begin
            inst_o       <= load_mem ? imem_rdata_i : skid_word;
            inst_valid_o <= 1'b1;
            pre_pc_o     <= pc_o;
            pc_o         <= target;
         end else if (bubble) begin
            inst_valid_o <= 1'b0;
         end
      end
   end

`ifdef PC_SEQ_EXC_EN
   // Exception PC capture and the address of the request being drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         epc_o      <= '0;
         drain_addr <= '0;
      end else if (exc_take) begin
         epc_o <= pre_pc_o;
         if (state == FETCH) drain_addr <= pc_o;
      end
   end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a queue-based behavioural model and
// per-cycle comparison, plus hand-computed literal checkpoints.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] npc_i;
   logic        stall_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic [31:0] pc_o;
   logic [31:0] pre_pc_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;
`ifdef PC_SEQ_EXC_EN
   logic        exc_i = 1'b0;
   logic [31:0] epc_o;
`endif

   int total = 0;
   int bad   = 0;

   // Next-PC logic stand-in: one programmable branch, otherwise sequential.
   logic        br_en   = 1'b0;
   logic [31:0] br_from = '0;
   logic [31:0] br_to   = '0;
   assign npc_i = (br_en && pre_pc_o == br_from) ? br_to : pc_o + 32'd4;

   int mem_wait = 0;
   int wcnt     = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .npc_i        (npc_i),
      .stall_i      (stall_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_rdata_i (imem_rdata_i),
      .pc_o         (pc_o),
      .pre_pc_o     (pre_pc_o),
      .inst_o       (inst_o),
      .inst_valid_o (inst_valid_o)
`ifdef PC_SEQ_EXC_EN
      ,
      .exc_i        (exc_i),
      .epc_o        (epc_o)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Memory: answers each request after mem_wait idle cycles, data = ~address.
   task automatic mem_drive();
      if (rst_n && imem_req_o) begin
         if (wcnt >= mem_wait) begin
            imem_ack_i   = 1'b1;
            imem_rdata_i = ~imem_addr_o;
            wcnt         = 0;
         end else begin
            imem_ack_i = 1'b0;
            wcnt++;
         end
      end else begin
         imem_ack_i = 1'b0;
      end
   endtask

   task automatic tick(input logic s);
      @(negedge clk);
      stall_i = s;
      mem_drive();
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc, m_pre, m_inst, m_epc, m_daddr;
   logic        m_valid, m_started, m_drain;
   logic [31:0] q[$];

   function automatic logic m_req();
      return m_started && (q.size() == 0);
   endfunction

   function automatic logic [31:0] m_addr();
      return m_drain ? m_daddr : m_pc;
   endfunction

   function automatic void deliver(input logic [31:0] w);
      logic [31:0] t;
      if (m_valid && br_en && m_pre == br_from) t = br_to;
      else                                      t = m_pc + 32'd4;
      m_pre   = m_pc;
      m_inst  = w;
      m_valid = 1'b1;
      m_pc    = t & 32'hFFFF_FFFC;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic req_now;
      if (!rst_n) begin
         m_pc = 32'h3000; m_pre = 32'h3000; m_inst = '0; m_epc = '0; m_daddr = '0;
         m_valid = 1'b0; m_started = 1'b0; m_drain = 1'b0;
         q.delete();
      end else begin
         req_now = m_req();
`ifdef PC_SEQ_EXC_EN
         if (exc_i) begin
            m_epc = m_pre;
            if (req_now && !imem_ack_i) begin
               if (!m_drain) m_daddr = m_pc;
               m_drain = 1'b1;
            end else begin
               m_drain = 1'b0;
            end
            m_pc = 32'h4180; m_valid = 1'b0; m_started = 1'b1;
            q.delete();
         end else if (m_drain) begin
            if (imem_ack_i) m_drain = 1'b0;
         end else
`endif
         if (!m_started) begin
            m_started = 1'b1;
         end else if (q.size() != 0) begin
            if (!stall_i) deliver(q.pop_front());
         end else if (imem_ack_i) begin
            if (stall_i) q.push_back(imem_rdata_i);
            else         deliver(imem_rdata_i);
         end else if (!stall_i) begin
            m_valid = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("cyc_pc",    pc_o,                 m_pc);
         chk("cyc_prepc", pre_pc_o,             m_pre);
         chk("cyc_inst",  inst_o,               m_inst);
         chk("cyc_valid", {31'd0, inst_valid_o}, {31'd0, m_valid});
         chk("cyc_req",   {31'd0, imem_req_o},   {31'd0, m_req()});
         if (m_req()) chk("cyc_addr", imem_addr_o, m_addr());
`ifdef PC_SEQ_EXC_EN
         chk("cyc_epc",   epc_o,                m_epc);
`endif
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pc",    pc_o,                  32'h3000);
      chk("rst_prepc", pre_pc_o,              32'h3000);
      chk("rst_inst",  inst_o,                32'h0);
      chk("rst_valid", {31'd0, inst_valid_o}, 32'h0);
      chk("rst_req",   {31'd0, imem_req_o},   32'h0);

      // Release; branch at 3004 to 3100 is armed from the start.
      @(negedge clk);
      rst_n = 1'b1;
      mem_drive();
      br_en = 1'b1; br_from = 32'h3004; br_to = 32'h3100;
      chk("idle_req",  {31'd0, imem_req_o},   32'h0);

      tick(1'b0);
      chk("first_req",   {31'd0, imem_req_o},   32'h1);
      chk("first_addr",  imem_addr_o,           32'h3000);
      chk("first_valid", {31'd0, inst_valid_o}, 32'h0);
      tick(1'b0);
      chk("seq0_prepc", pre_pc_o, 32'h3000);
      chk("seq0_inst",  inst_o,   32'hFFFF_CFFF);
      chk("seq0_pc",    pc_o,     32'h3004);
      tick(1'b0);
      chk("seq1_prepc", pre_pc_o, 32'h3004);
      chk("seq1_pc",    pc_o,     32'h3008);
      tick(1'b0);
      chk("slot_prepc", pre_pc_o, 32'h3008);
      chk("slot_pc",    pc_o,     32'h3100);
      tick(1'b0);
      chk("tgt_prepc",  pre_pc_o, 32'h3100);
      chk("tgt_pc",     pc_o,     32'h3104);
      br_en = 1'b0;

      // Stall held for three edges while 3108 is acknowledged.
      tick(1'b1);
      chk("stl0_prepc", pre_pc_o, 32'h3104);
      chk("stl0_req",   {31'd0, imem_req_o}, 32'h1);
      tick(1'b1);
      chk("stl1_req",   {31'd0, imem_req_o}, 32'h0);
      chk("stl1_prepc", pre_pc_o, 32'h3104);
      tick(1'b1);
      chk("stl2_req",   {31'd0, imem_req_o}, 32'h0);
      chk("stl2_inst",  inst_o,   32'hFFFF_CEFB);
      tick(1'b0);
      chk("stl3_prepc", pre_pc_o, 32'h3104);
      tick(1'b0);
      chk("skid_prepc", pre_pc_o, 32'h3108);
      chk("skid_inst",  inst_o,   32'hFFFF_CEF7);
      chk("skid_valid", {31'd0, inst_valid_o}, 32'h1);
      tick(1'b0);
      chk("skid_next",  pre_pc_o, 32'h310C);

      // Two wait states; a branch decoded at 3110 must be ignored once bubbled.
      mem_wait = 2;
      br_en = 1'b1; br_from = 32'h3110; br_to = 32'h3400;
      tick(1'b0);
      chk("ws_prepc", pre_pc_o, 32'h3110);
      chk("ws_pc",    pc_o,     32'h3114);
      tick(1'b0);
      chk("ws_bub0",  {31'd0, inst_valid_o}, 32'h0);
      tick(1'b0);
      chk("ws_bub1",  {31'd0, inst_valid_o}, 32'h0);
      chk("ws_hold",  pre_pc_o, 32'h3110);
      mem_wait = 0;
      tick(1'b0);
      chk("ws_prepc2", pre_pc_o, 32'h3114);
      chk("ws_seqpc",  pc_o,     32'h3118);
      br_en = 1'b0;

      // Branch to FFFF_FFFC, then sequential wrap to zero.
      tick(1'b0);
      chk("pre_wrap", pre_pc_o, 32'h3118);
      br_en = 1'b1; br_from = 32'h311C; br_to = 32'hFFFF_FFFC;
      tick(1'b0);
      chk("wrap_b",   pre_pc_o,   32'h311C);
      tick(1'b0);
      chk("wrap_top", imem_addr_o, 32'hFFFF_FFFC);
      tick(1'b0);
      chk("wrap_pc",   pc_o,        32'h0);
      chk("wrap_addr", imem_addr_o, 32'h0);
      chk("wrap_inst", inst_o,      32'h0000_0003);
      br_en = 1'b0;
      tick(1'b0);
      chk("wrap_next", pc_o, 32'h4);

      // Reset asserted while a request is outstanding.
      #3 rst_n = 1'b0;
      #1;
      chk("mrst_req", {31'd0, imem_req_o}, 32'h0);
      chk("mrst_pc",  pc_o, 32'h3000);
      imem_ack_i = 1'b0;
      wcnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      mem_drive();
      tick(1'b0);
      tick(1'b0);
      chk("mrst_prepc", pre_pc_o, 32'h3000);

`ifdef PC_SEQ_EXC_EN
      // Exception while the 3014 request waits for memory.
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
      mem_wait = 3;
      tick(1'b0);
      chk("exc_prepc", pre_pc_o, 32'h3010);
      exc_i = 1'b1;
      tick(1'b0);
      exc_i = 1'b0;
      chk("exc_epc",   epc_o,       32'h3010);
      chk("exc_daddr", imem_addr_o, 32'h3014);
      chk("exc_valid", {31'd0, inst_valid_o}, 32'h0);
      tick(1'b0);
      tick(1'b0);
      mem_wait = 0;
      tick(1'b0);
      chk("exc_vec",   imem_addr_o, 32'h4180);
      chk("exc_valid2", {31'd0, inst_valid_o}, 32'h0);
      tick(1'b0);
      chk("exc_first", pre_pc_o, 32'h4180);
      chk("exc_inst",  inst_o,   32'hFFFF_BE7F);
`endif

      tick(1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
